// File: rtl/motor_pwm_driver.sv
// Four-channel ESC pulse generator with frame timing, arming sequence and
// frame-aligned rate updates. Optional rate watchdog: MOTOR_PWM_WATCHDOG_EN.
module motor_pwm_driver #(
    parameter int MOTOR_RATE_BIT_WIDTH = 36,
    parameter int FRAME_TICKS          = 95000,
    parameter int MIN_PULSE_TICKS      = 38000,
    parameter int MAX_PULSE_TICKS      = 76000,
    parameter int ARM_FRAMES           = 400
) (
    input  logic                            sys_clk,
    input  logic                            rst,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
    input  logic                            rate_valid,
    input  logic                            arm,
    output logic                            pwm_1,
    output logic                            pwm_2,
    output logic                            pwm_3,
    output logic                            pwm_4,
    output logic                            frame_start,
    output logic                            armed
);

    localparam int RW    = MOTOR_RATE_BIT_WIDTH;
    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int AC_W  = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES + 1) : 1;
    localparam int SPAN  = MAX_PULSE_TICKS - MIN_PULSE_TICKS;
    localparam int CW    = (RW > 32) ? RW : 32;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [AC_W-1:0]  ARM_LAST = AC_W'(ARM_FRAMES - 1);

    typedef enum logic [1:0] {
        DISARMED,
        ARMING,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AC_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [RW-1:0]    rate_in   [4];
    logic [RW-1:0]    hold_q    [4];
    logic [RW-1:0]    shadow_q  [4];
    logic [RW-1:0]    shadow_d  [4];
    logic [31:0]      width     [4];
    logic [3:0]       pwm_q, pwm_d;
    logic             frame_tick;

    assign rate_in[0] = motor_1_rate;
    assign rate_in[1] = motor_2_rate;
    assign rate_in[2] = motor_3_rate;
    assign rate_in[3] = motor_4_rate;

    assign frame_tick  = (cnt_q == '0);
    // Counter sits at zero through reset, so gate the strobe until release.
    assign frame_start = frame_tick & ~rst;
    assign armed       = (state_q == RUN);

    assign pwm_1 = pwm_q[0];
    assign pwm_2 = pwm_q[1];
    assign pwm_3 = pwm_q[2];
    assign pwm_4 = pwm_q[3];

    // Saturating rate-to-width map, compared at full input width.
    function automatic logic [31:0] pulse_w(input logic [RW-1:0] r);
        logic [CW-1:0] rx;
        rx = CW'(r);
        if (rx > CW'(SPAN))
            return 32'(MAX_PULSE_TICKS);
        else
            return 32'(MIN_PULSE_TICKS) + 32'(rx);
    endfunction

    // Frame counter: 0 .. FRAME_TICKS-1, then wrap.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (cnt_q == CNT_LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    // Holding register: every strobe is captured, last one wins.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            hold_q <= '{default: '0};
        else if (rate_valid)
            hold_q <= rate_in;
    end

`ifdef MOTOR_PWM_WATCHDOG_EN
    logic [5:0] wd_q;
    logic       wd_expired;

    assign wd_expired = (wd_q >= 6'd50);

    // Frames seen in RUN since the last rate strobe, saturating at 50.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            wd_q <= '0;
        else if (state_q != RUN || rate_valid)
            wd_q <= '0;
        else if (frame_tick && !wd_expired)
            wd_q <= wd_q + 6'd1;
    end
`endif

    // Shadow load at frame start, with a same-cycle strobe bypassing hold.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_tick) begin
            shadow_d = rate_valid ? rate_in : hold_q;
`ifdef MOTOR_PWM_WATCHDOG_EN
            if (state_q == RUN && !rate_valid && wd_expired)
                shadow_d = '{default: '0};
`endif
        end
    end

    // Shadow register: the rates governing the current frame.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            shadow_q <= '{default: '0};
        else
            shadow_q <= shadow_d;
    end

    // Next state and arming frame count.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        unique case (state_q)
            DISARMED: begin
                arm_cnt_d = '0;
                if (frame_tick && arm)
                    state_d = ARMING;
            end
            ARMING: begin
                if (!arm) begin
                    state_d   = DISARMED;
                    arm_cnt_d = '0;
                end else if (frame_tick) begin
                    if (arm_cnt_q >= ARM_LAST) begin
                        state_d   = RUN;
                        arm_cnt_d = '0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!arm) begin
                    state_d   = DISARMED;
                    arm_cnt_d = '0;
                end
            end
            default: begin
                state_d   = DISARMED;
                arm_cnt_d = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q   <= DISARMED;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // Pulse compare, driven by the state the frame is entering.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < 4; i++) begin
            width[i] = pulse_w(shadow_d[i]);
            if (state_d == ARMING)
                pwm_d[i] = (32'(cnt_q) < 32'(MIN_PULSE_TICKS));
            else if (state_d == RUN)
                pwm_d[i] = (32'(cnt_q) < width[i]);
        end
    end

    // Registered pulse outputs, cleared asynchronously by reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            pwm_q <= '0;
        else
            pwm_q <= pwm_d;
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed and random frames checked against
// a per-frame pulse-width model. Honours MOTOR_PWM_WATCHDOG_EN.
module tb_motor_pwm_driver;

    localparam int FT  = 100;
    localparam int MN  = 10;
    localparam int MX  = 20;
    localparam int AF  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] rt [4];
    logic        rate_valid;
    logic        arm;
    logic        pwm_1, pwm_2, pwm_3, pwm_4;
    logic        frame_start;
    logic        armed;

    int vecs  = 0;
    int fails = 0;

    logic [35:0] nr   [4];
    logic [35:0] pend [4];
    logic [35:0] cur  [4];
    int          since;
    bit          prev_run;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .MOTOR_RATE_BIT_WIDTH(36),
        .FRAME_TICKS(FT),
        .MIN_PULSE_TICKS(MN),
        .MAX_PULSE_TICKS(MX),
        .ARM_FRAMES(AF)
    ) dut (
        .sys_clk(clk),
        .rst(rst),
        .motor_1_rate(rt[0]),
        .motor_2_rate(rt[1]),
        .motor_3_rate(rt[2]),
        .motor_4_rate(rt[3]),
        .rate_valid(rate_valid),
        .arm(arm),
        .pwm_1(pwm_1),
        .pwm_2(pwm_2),
        .pwm_3(pwm_3),
        .pwm_4(pwm_4),
        .frame_start(frame_start),
        .armed(armed)
    );

    function automatic logic [3:0] pwms();
        return {pwm_4, pwm_3, pwm_2, pwm_1};
    endfunction

    function automatic int exp_w(input logic [35:0] x);
        if (x > 36'(MX - MN))
            return MX;
        return MN + int'(x[7:0]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sync_to_frame(input string tag);
        bit found = 0;
        for (int k = 0; k < 3 * FT; k++) begin
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_sync"}, 64'(found), 64'd1);
    endtask

    // Called at the negedge of a frame_start cycle; runs one whole frame.
    // mode: 0 disarmed, 1 arming, 2 run. sa: cycle of the strobe, -1 none.
    task automatic measure_frame(input int sa, input int mode,
                                 input string tag);
        int  cw [4];
        bit  run;
        bit  expired;
        run     = (mode == 2);
        expired = 0;
        cw      = '{default: 0};
        if (sa == 0)
            pend = nr;
        if (!prev_run)
            since = 0;
        else if (sa == 0)
            since = 0;
        else begin
            expired = (since >= 50);
            if (since < 50)
                since++;
        end
`ifdef MOTOR_PWM_WATCHDOG_EN
        cur = expired ? '{default: '0} : pend;
`else
        cur = pend;
`endif
        for (int i = 0; i < FT; i++) begin
            if (i == sa) begin
                rt         = nr;
                rate_valid = 1'b1;
            end
            @(negedge clk);
            if (i == sa) begin
                rate_valid = 1'b0;
                for (int m = 0; m < 4; m++)
                    rt[m] = {4'($urandom), $urandom};
                if (i != 0) begin
                    pend  = nr;
                    since = 0;
                end
            end
            for (int m = 0; m < 4; m++)
                cw[m] += int'(pwms() >> m) & 1;
            if (i == 49) begin
                check({tag, "_armed"}, 64'(armed), 64'(run));
                check({tag, "_fs_mid"}, 64'(frame_start), 64'd0);
            end
        end
        check({tag, "_fs_period"}, 64'(frame_start), 64'd1);
        for (int m = 0; m < 4; m++) begin
            int e;
            e = (mode == 0) ? 0 : (mode == 1) ? MN : exp_w(cur[m]);
            check($sformatf("%s_w%0d", tag, m + 1), 64'(cw[m]), 64'(e));
        end
        prev_run = run;
    endtask

    initial begin
        rst        = 1'b1;
        arm        = 1'b0;
        rate_valid = 1'b0;
        rt         = '{default: '0};
        nr         = '{default: '0};
        pend       = '{default: '0};
        cur        = '{default: '0};
        since      = 0;
        prev_run   = 0;

        repeat (3) @(negedge clk);
        check("rst_fs", 64'(frame_start), 64'd0);
        check("rst_pwm", 64'(pwms()), 64'd0);
        check("rst_armed", 64'(armed), 64'd0);

        rst = 1'b0;
        #1;
        check("rel_fs", 64'(frame_start), 64'd1);

        measure_frame(-1, 0, "idle0");
        measure_frame(-1, 0, "idle1");

        repeat (30) @(negedge clk);
        arm = 1'b1;
        sync_to_frame("arm");
        measure_frame(-1, 1, "arming0");
        nr = '{default: 36'd3};
        measure_frame(40, 1, "arming1");
        measure_frame(-1, 2, "run0");

        nr = '{36'd0, 36'd5, 36'd10, 36'd999};
        measure_frame(50, 2, "rates_pre");
        measure_frame(-1, 2, "rates");
        nr = '{36'hF_FFFF_FFFF, 36'd11, 36'd1, 36'd10};
        measure_frame(50, 2, "sat_pre");
        measure_frame(-1, 2, "sat");

        nr = '{default: 36'd7};
        measure_frame(0, 2, "bypass");
        nr = '{default: 36'd3};
        measure_frame(50, 2, "late_strobe");
        measure_frame(-1, 2, "late_next");

        for (int f = 0; f < 12; f++) begin
            int sa;
            for (int m = 0; m < 4; m++) begin
                case ($urandom_range(0, 3))
                    0: nr[m] = 36'($urandom_range(0, 12));
                    1: nr[m] = {4'($urandom), $urandom};
                    2: nr[m] = 36'hF_FFFF_FFFF;
                    default: nr[m] = 36'($urandom_range(10, 11));
                endcase
            end
            case ($urandom_range(0, 2))
                0: sa = -1;
                1: sa = 0;
                default: sa = $urandom_range(1, FT - 1);
            endcase
            measure_frame(sa, 2, $sformatf("rnd%0d", f));
        end

        nr = '{default: 36'd6};
        measure_frame(50, 2, "quiet_pre");
        for (int f = 0; f < 51; f++)
            measure_frame(-1, 2, $sformatf("quiet%0d", f));
        nr = '{default: 36'd4};
        measure_frame(50, 2, "restore_pre");
        measure_frame(-1, 2, "restore");

        repeat (5) @(negedge clk);
        check("drop_mid", 64'(pwms()), 64'hF);
        arm = 1'b0;
        @(negedge clk);
        check("drop_pwm", 64'(pwms()), 64'd0);
        check("drop_armed", 64'(armed), 64'd0);
        repeat (20) @(negedge clk);
        check("drop_hold", 64'(pwms()), 64'd0);
        arm = 1'b1;
        sync_to_frame("rearm");
        prev_run = 0;
        measure_frame(-1, 1, "rearm0");
        measure_frame(-1, 1, "rearm1");
        measure_frame(-1, 2, "rearm_run");

        repeat (5) @(negedge clk);
        check("ar_mid", 64'(pwms()), 64'hF);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pwm", 64'(pwms()), 64'd0);
        check("ar_armed", 64'(armed), 64'd0);
        check("ar_fs", 64'(frame_start), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar_rel_fs", 64'(frame_start), 64'd1);
        prev_run = 0;
        pend     = '{default: '0};
        measure_frame(-1, 1, "post0");
        measure_frame(-1, 1, "post1");
        measure_frame(-1, 2, "post_run");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
